// File: rtl/smc_pkg.sv
// Shared types and constants for the serial device loader.
//   state_t      : loader FSM states
//   N_DEV        : devices per frame
//   WT0..WT2     : ID-mode weights applied to s0, s1, s2
//   VAL_W, RES_W : per-device value width and frame result width
//   frame_result : combines the three selected sorted values into a frame result
package smc_pkg;

    localparam int N_DEV = 6;
    localparam int VAL_W = 10;
    localparam int RES_W = 10;

    localparam int WT0 = 3;
    localparam int WT1 = 4;
    localparam int WT2 = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SUM,
        OUT
    } state_t;

    typedef logic [VAL_W-1:0] val_t;
    typedef logic [RES_W-1:0] res_t;

    // Plain sum for gm frames, weighted sum for ID frames; wraps modulo 2**RES_W.
    function automatic res_t frame_result(input logic id_sel, input val_t s0,
                                          input val_t s1, input val_t s2);
        if (id_sel)
            return res_t'(WT0 * s0 + WT1 * s1 + WT2 * s2);
        else
            return res_t'(s0 + s1 + s2);
    endfunction

endpackage

// File: rtl/smc_serial_loader_if.sv
// Handshake bundle between the device-beat producer / result consumer and the loader.
//   in_valid/in_ready      : beat handshake
//   mode                   : bit0 selects ID (1) or gm (0); bit1 selects larger (1) or smaller (0) three
//   W, V_GS, V_DS          : one device's 3-bit unsigned parameters per beat
//   out_valid/out_ready    : result handshake
//   out_n                  : frame result
// master: producer/consumer side; slave: the loader.
interface smc_serial_loader_if;
    import smc_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic [1:0] mode;
    logic [2:0] W;
    logic [2:0] V_GS;
    logic [2:0] V_DS;
    logic       out_valid;
    logic       out_ready;
    res_t       out_n;

    modport master (
        output in_valid, mode, W, V_GS, V_DS, out_ready,
        input  in_ready, out_valid, out_n
    );

    modport slave (
        input  in_valid, mode, W, V_GS, V_DS, out_ready,
        output in_ready, out_valid, out_n
    );

endinterface

// File: rtl/smc_dev_calc.sv
// Per-device ID / gm value, purely combinational.
//   id_sel : 1 = drain current ID, 0 = transconductance gm
//   w, v_gs, v_ds : 3-bit unsigned device parameters
//   value  : resulting 10-bit value (floor of the /3 scaled expression)
module smc_dev_calc
    import smc_pkg::*;
(
    input  logic       id_sel,
    input  logic [2:0] w,
    input  logic [2:0] v_gs,
    input  logic [2:0] v_ds,
    output val_t       value
);

    logic       is_triode;
    logic [2:0] vgs_m1;
    logic [3:0] tri_fac;
    val_t       prod;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        is_triode = 1'b0;
        vgs_m1    = '0;
        tri_fac   = '0;
        prod      = '0;

        // V_GS-1 deliberately wraps at 3 bits: V_GS=0 behaves as 7.
        vgs_m1    = v_gs - 3'd1;
        is_triode = {1'b0, v_gs} > ({1'b0, v_ds} + 4'd1);
        // Only meaningful in triode, where it is always positive and fits 4 bits.
        tri_fac   = {v_gs, 1'b0} - {1'b0, v_ds} - 4'd2;

        if (id_sel) begin
            if (is_triode)
                prod = val_t'(v_ds) * val_t'(w) * val_t'(tri_fac);
            else
                prod = val_t'(w) * val_t'(vgs_m1) * val_t'(vgs_m1);
        end else begin
            if (is_triode)
                prod = val_t'({w, 1'b0}) * val_t'(v_ds);
            else
                prod = val_t'({w, 1'b0}) * val_t'(vgs_m1);
        end
    end

    assign value = prod / val_t'(3);

endmodule

// File: rtl/smc_serial_loader.sv
// Serial device loader: accepts N_DEV device beats, keeps their ID or gm values in
// a descending sorted list, then emits a sum of either the larger or smaller three.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : beat input and result output handshakes (slave side)
module smc_serial_loader
    import smc_pkg::*;
#(
    parameter int N_DEV = smc_pkg::N_DEV
) (
    input  logic                clk,
    input  logic                reset,
    smc_serial_loader_if.slave  bus
);

    state_t     state, state_nxt;
    logic [1:0] mode_q;
    logic [2:0] beat_cnt;
    val_t       sorted_q   [N_DEV];
    val_t       sorted_ins [N_DEV];
    val_t       beat_val;
    logic [1:0] mode_eff;
    logic       accept;
    val_t       s0, s1, s2;
    logic       out_valid_q;
    res_t       out_n_q;

    assign bus.in_ready  = (state == IDLE) || (state == LOAD);
    assign bus.out_valid = out_valid_q;
    assign bus.out_n     = out_n_q;

    // in_ready is a pure function of state, so accept is safe to use here.
    assign accept = bus.in_valid && ((state == IDLE) || (state == LOAD));

    // Mode is taken live on the first beat and from the latched copy afterwards.
    assign mode_eff = (state == IDLE) ? bus.mode : mode_q;

    smc_dev_calc u_calc (
        .id_sel (mode_eff[0]),
        .w      (bus.W),
        .v_gs   (bus.V_GS),
        .v_ds   (bus.V_DS),
        .value  (beat_val)
    );

    // Insertion into the descending list: an entry keeps its value while it is
    // still >= the new one, the first smaller slot takes the new value, and every
    // later slot takes its predecessor. Unused slots hold 0, so after N_DEV
    // inserts the list is exactly the sorted frame.
    always_comb begin
        sorted_ins[0] = (sorted_q[0] >= beat_val) ? sorted_q[0] : beat_val;
        for (int i = 1; i < N_DEV; i++) begin
            if (sorted_q[i] >= beat_val)
                sorted_ins[i] = sorted_q[i];
            else if (sorted_q[i-1] >= beat_val)
                sorted_ins[i] = beat_val;
            else
                sorted_ins[i] = sorted_q[i-1];
        end
    end

    always_comb begin
        s0 = mode_q[1] ? sorted_q[0] : sorted_q[N_DEV-3];
        s1 = mode_q[1] ? sorted_q[1] : sorted_q[N_DEV-2];
        s2 = mode_q[1] ? sorted_q[2] : sorted_q[N_DEV-1];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = LOAD;
            LOAD:    if (accept && (beat_cnt == 3'(N_DEV - 1))) state_nxt = SUM;
            SUM:     state_nxt = OUT;
            OUT:     if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            // NOTE: the sorted list must be reset because unused slots act as
            // zero-valued entries during insertion.
            sorted_q    <= '{default: '0};
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q   <= bus.mode;
                        beat_cnt <= 3'd1;
                        sorted_q <= sorted_ins;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        beat_cnt <= beat_cnt + 3'd1;
                        sorted_q <= sorted_ins;
                    end
                end
                SUM: begin
                    out_n_q     <= frame_result(mode_q[0], s0, s1, s2);
                    out_valid_q <= 1'b1;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        beat_cnt    <= '0;
                        sorted_q    <= '{default: '0};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_smc_serial_loader.sv
// Self-checking bench for smc_serial_loader: a behavioural model computes each
// frame's result when the frame is driven, a monitor compares on each output handshake.
module tb_smc_serial_loader;
    import smc_pkg::*;

    typedef int arr6_t [6];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    smc_serial_loader_if bus ();

    smc_serial_loader #(.N_DEV(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_q [$];
    int last_accept_cyc = 0;
    int first_accept_cyc = 0;
    int handshake_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int dev_model(input bit id, input int w, input int vgs, input int vds);
        int vm1;
        bit tr;
        vm1 = (vgs + 7) % 8;
        tr  = vgs > vds + 1;
        if (id) return tr ? (vds * w * (2 * vgs - vds - 2)) / 3 : (w * vm1 * vm1) / 3;
        else    return tr ? (2 * w * vds) / 3 : (2 * w * vm1) / 3;
    endfunction

    function automatic int frame_model(input bit [1:0] m, input arr6_t w,
                                       input arr6_t vgs, input arr6_t vds);
        int v [6];
        int t, a, b, c, r;
        for (int i = 0; i < 6; i++) v[i] = dev_model(m[0], w[i], vgs[i], vds[i]);
        for (int i = 0; i < 6; i++)
            for (int j = i + 1; j < 6; j++)
                if (v[j] > v[i]) begin t = v[i]; v[i] = v[j]; v[j] = t; end
        a = m[1] ? v[0] : v[3];
        b = m[1] ? v[1] : v[4];
        c = m[1] ? v[2] : v[5];
        r = m[0] ? (3 * a + 4 * b + 5 * c) : (a + b + c);
        return r % 1024;
    endfunction

    // Drives one beat from a falling edge, waits (bounded) for in_ready, and
    // returns the edge number on which the beat was accepted.
    task automatic drive_beat(input bit [1:0] m, input int w, input int vgs,
                              input int vds, output int acc_cyc);
        int t;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.W        = 3'(w);
        bus.V_GS     = 3'(vgs);
        bus.V_DS     = 3'(vds);
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.W        = 3'd7;
        bus.V_GS     = 3'd7;
        bus.V_DS     = 3'd0;
    endtask

    // Mode is inverted on beats 2..6 so a loader that re-samples mode is caught.
    task automatic send_frame(input bit [1:0] m, input arr6_t w, input arr6_t vgs,
                              input arr6_t vds, input int gap);
        int acc;
        exp_q.push_back(frame_model(m, w, vgs, vds));
        for (int i = 0; i < 6; i++) begin
            if (i > 0) repeat (gap) @(negedge clk);
            drive_beat((i == 0) ? m : ~m, w[i], vgs[i], vds[i], acc);
            if (i == 0) first_accept_cyc = acc;
        end
        last_accept_cyc = acc;
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!bus.out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("valid_seen", int'(bus.out_valid), 1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Output monitor: latency on each rising out_valid, value on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && !prev_valid)
                check("latency", (cyc + 1) - last_accept_cyc, 2);
            if (reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else                   check("out_n", int'(bus.out_n), exp_q.pop_front());
                handshake_cyc = cyc + 1;
            end
            prev_valid = bus.out_valid;
        end
    end

    initial begin
        int acc;
        bus.in_valid  = 1'b0;
        bus.mode      = 2'b00;
        bus.W         = 3'd0;
        bus.V_GS      = 3'd0;
        bus.V_DS      = 3'd0;
        bus.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_n", int'(bus.out_n), 0);
        check("reset_in_ready", int'(bus.in_ready), 1);

        // Triode ID, larger three: every value 1 -> 12.
        send_frame(2'b11, '{1,1,1,1,1,1}, '{3,3,3,3,3,3}, '{1,1,1,1,1,1}, 0);
        wait_drain();

        // Saturation gm, smaller three: values 0,1,2,2,3,4 -> 3.
        send_frame(2'b00, '{1,2,3,4,5,6}, '{2,2,2,2,2,2}, '{2,2,2,2,2,2}, 0);
        wait_drain();

        // V_GS wrap: each value 114, 1368 wraps to 344.
        send_frame(2'b11, '{7,7,7,7,7,7}, '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 0);
        wait_drain();

        // Mixed data back-to-back and with in_valid toggling: same result expected.
        send_frame(2'b01, '{3,7,2,5,1,6}, '{5,7,1,4,0,6}, '{1,3,0,4,2,7}, 0);
        wait_drain();
        send_frame(2'b01, '{3,7,2,5,1,6}, '{5,7,1,4,0,6}, '{1,3,0,4,2,7}, 1);
        wait_drain();
        send_frame(2'b10, '{6,4,7,1,3,2}, '{7,3,6,2,5,1}, '{2,0,5,1,1,6}, 2);
        wait_drain();

        // Consumer stall: result and in_ready must hold while out_ready is low.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send_frame(2'b11, '{1,1,1,1,1,1}, '{3,3,3,3,3,3}, '{1,1,1,1,1,1}, 0);
        wait_valid();
        bus.in_valid = 1'b1;
        bus.mode     = 2'b11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", int'(bus.out_valid), 1);
            check("stall_out_n", int'(bus.out_n), 12);
            check("stall_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send_frame(2'b00, '{1,2,3,4,5,6}, '{2,2,2,2,2,2}, '{2,2,2,2,2,2}, 0);
        check("accept_after_handshake", int'(first_accept_cyc > handshake_cyc), 1);
        wait_drain();

        // Reset after three beats discards the partial frame.
        for (int i = 0; i < 3; i++) drive_beat(2'b11, 7, 0, 0, acc);
        pulse_reset();
        check("mid_load_reset_out_valid", int'(bus.out_valid), 0);
        check("mid_load_reset_in_ready", int'(bus.in_ready), 1);
        send_frame(2'b11, '{1,1,1,1,1,1}, '{3,3,3,3,3,3}, '{1,1,1,1,1,1}, 0);
        wait_drain();

        // Reset while a result is pending: it is dropped and no out_valid follows.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send_frame(2'b11, '{7,7,7,7,7,7}, '{0,0,0,0,0,0}, '{0,0,0,0,0,0}, 0);
        wait_valid();
        pulse_reset();
        void'(exp_q.pop_back());
        bus.out_ready = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (bus.out_valid) seen++;
            end
            check("mid_out_reset_no_valid", seen, 0);
        end
        check("mid_out_reset_out_n", int'(bus.out_n), 0);

        // Loader is usable again after the pending-result reset.
        send_frame(2'b00, '{1,2,3,4,5,6}, '{2,2,2,2,2,2}, '{2,2,2,2,2,2}, 0);
        wait_drain();

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
